// File: rtl/mem_stage_dm_pkg.sv
// rtl/mem_stage_dm_pkg.sv - shared opcodes, result tags and data memory depth for the MEM stage
package mem_stage_dm_pkg;

    localparam int DM_WORDS_DEFAULT = 3072;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;
    localparam logic [2:0] RES_MD  = 3'd4;

endpackage

// File: rtl/mem_stage_dm_byte_lane.sv
// rtl/mem_stage_dm_byte_lane.sv - store byte merge and load lane extract/extend
module dm_byte_lane
    import mem_stage_dm_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic        is_store,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [3:0]  be;
    logic [31:0] repl;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be       = 4'b0000;
        repl     = wdata;
        is_store = 1'b0;
        case (op)
            OP_SW: begin
                be       = 4'b1111;
                is_store = 1'b1;
            end
            OP_SH: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                repl     = {2{wdata[15:0]}};
                is_store = 1'b1;
            end
            OP_SB: begin
                be       = 4'b0001 << lane;
                repl     = {4{wdata[7:0]}};
                is_store = 1'b1;
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged_word[8*i +: 8] = be[i] ? repl[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    always_comb begin
        case (lane)
            2'd0:    rbyte = old_word[7:0];
            2'd1:    rbyte = old_word[15:8];
            2'd2:    rbyte = old_word[23:16];
            default: rbyte = old_word[31:24];
        endcase
        rhalf = lane[1] ? old_word[31:16] : old_word[15:0];
        case (op)
            OP_LW:   load_data = old_word;
            OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  load_data = {24'd0, rbyte};
            OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  load_data = {16'd0, rhalf};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage_dm.sv
// rtl/mem_stage_dm.sv - MEM stage: data memory access and M/W pipeline register
module mem_stage_dm
    import mem_stage_dm_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEFAULT,
    parameter int ADDR_W   = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC8_M,
    input  logic [4:0]  A3_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] RD2_M,
    input  logic [2:0]  RES_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC8_W,
    output logic [4:0]  A3_W,
    output logic [31:0] AO_W,
    output logic [31:0] DR_W,
    output logic [2:0]  RES_W
);

    logic [31:0]       mem [DM_WORDS];
    logic [ADDR_W-1:0] word_idx;
    logic              in_range;
    logic [31:0]       cur_word;
    logic              is_store;
    logic [31:0]       merged_word;
    logic [31:0]       load_data;

    assign word_idx = AO_M[ADDR_W+1:2];
    assign in_range = ({{(32-ADDR_W){1'b0}}, word_idx} < 32'(DM_WORDS));
    // Out-of-range reads return zero so the extender sees a clean word.
    assign cur_word = in_range ? mem[word_idx] : 32'd0;

    dm_byte_lane u_lane (
        .op          (IR_M[31:26]),
        .lane        (AO_M[1:0]),
        .wdata       (RD2_M),
        .old_word    (cur_word),
        .is_store    (is_store),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
            IR_W  <= 32'd0;
            PC8_W <= 32'd0;
            A3_W  <= 5'd0;
            AO_W  <= 32'd0;
            DR_W  <= 32'd0;
            RES_W <= 3'd0;
        end else begin
            if (is_store && in_range) begin
                mem[word_idx] <= merged_word;
            end
            IR_W  <= IR_M;
            PC8_W <= PC8_M;
            A3_W  <= A3_M;
            AO_W  <= AO_M;
            DR_W  <= load_data;
            RES_W <= RES_M;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && is_store && in_range) begin
            $display("%d@%h: *%h <= %h", $time, PC8_M - 32'd8, {AO_M[31:2], 2'b00}, merged_word);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_dm.sv
// tb/tb_mem_stage_dm.sv - randomized scoreboard bench for mem_stage_dm
module tb_mem_stage_dm;

    localparam logic [5:0] LW = 6'h23, LB = 6'h20, LBU = 6'h24, LH = 6'h21, LHU = 6'h25;
    localparam logic [5:0] SW = 6'h2B, SH = 6'h29, SB = 6'h28, ADDU = 6'h00, ORI = 6'h0D;
    localparam int WORDS = 3072;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M, PC8_M, AO_M, RD2_M;
    logic [4:0]  A3_M;
    logic [2:0]  RES_M;
    logic [31:0] IR_W, PC8_W, AO_W, DR_W;
    logic [4:0]  A3_W;
    logic [2:0]  RES_W;

    typedef struct {
        logic [31:0] ir, pc8, ao, dr;
        logic [4:0]  a3;
        logic [2:0]  res;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [WORDS];
    int          checks = 0;
    int          errors = 0;

    mem_stage_dm dut (
        .clk(clk), .reset(reset), .IR_M(IR_M), .PC8_M(PC8_M), .A3_M(A3_M),
        .AO_M(AO_M), .RD2_M(RD2_M), .RES_M(RES_M), .IR_W(IR_W), .PC8_W(PC8_W),
        .A3_W(A3_W), .AO_W(AO_W), .DR_W(DR_W), .RES_W(RES_W)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory behaviour computed with plain arithmetic.
    task automatic issue(input bit rst, input logic [5:0] op, input logic [31:0] ao, input logic [31:0] rd2);
        exp_t        e;
        logic [31:0] w, b, h, sh;
        int          idx;
        reset = rst;
        IR_M  = {op, 26'($urandom)};
        PC8_M = $urandom;
        A3_M  = 5'($urandom);
        RES_M = 3'($urandom);
        AO_M  = ao;
        RD2_M = rd2;
        idx = int'(ao[13:2]);
        w   = (idx < WORDS) ? model[idx] : 32'd0;
        sh  = 32'(ao[1:0]) * 8;
        e   = '{ir: 32'd0, pc8: 32'd0, ao: 32'd0, dr: 32'd0, a3: 5'd0, res: 3'd0};
        if (rst) begin
            for (int i = 0; i < WORDS; i++) model[i] = 32'd0;
        end else begin
            e.ir = IR_M; e.pc8 = PC8_M; e.ao = ao; e.a3 = A3_M; e.res = RES_M;
            b = (w >> sh) & 32'hFF;
            h = (w >> (ao[1] ? 16 : 0)) & 32'hFFFF;
            case (op)
                LW:  e.dr = w;
                LB:  e.dr = (b >= 128) ? b - 256 : b;
                LBU: e.dr = b;
                LH:  e.dr = (h >= 32768) ? h - 65536 : h;
                LHU: e.dr = h;
                SW:  if (idx < WORDS) model[idx] = rd2;
                SH:  if (idx < WORDS) model[idx] = (w & ~(32'hFFFF << (ao[1] ? 16 : 0)))
                                                   | ((rd2 & 32'hFFFF) << (ao[1] ? 16 : 0));
                SB:  if (idx < WORDS) model[idx] = (w & ~(32'hFF << sh)) | ((rd2 & 32'hFF) << sh);
                default: ;
            endcase
        end
        q.push_back(e);
    endtask

    task automatic step(input bit rst, input logic [5:0] op, input logic [31:0] ao, input logic [31:0] rd2);
        @(negedge clk);
        issue(rst, op, ao, rd2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("IR_W", IR_W, e.ir);
                chk("PC8_W", PC8_W, e.pc8);
                chk("A3_W", 32'(A3_W), 32'(e.a3));
                chk("AO_W", AO_W, e.ao);
                chk("DR_W", DR_W, e.dr);
                chk("RES_W", 32'(RES_W), 32'(e.res));
            end
        end
    end

    initial begin : stimulus
        logic [5:0]  ops [10];
        logic [31:0] ao;
        ops = '{LW, LB, LBU, LH, LHU, SW, SH, SB, ADDU, ORI};
        issue(1'b1, LW, 32'h0, 32'h0);
        step(1'b1, LW, 32'h0, 32'h0);
        step(1'b0, LW, 32'h0000, 32'h0);
        step(1'b0, SW, 32'h0010, 32'h12345678);
        step(1'b0, LW, 32'h0010, 32'h0);
        step(1'b0, SW, 32'h0020, 32'h11223344);
        step(1'b0, SB, 32'h0022, 32'h000000AB);
        step(1'b0, LW, 32'h0020, 32'h0);
        step(1'b0, LB, 32'h0022, 32'h0);
        step(1'b0, LBU, 32'h0022, 32'h0);
        step(1'b0, SH, 32'h0032, 32'h00008001);
        step(1'b0, LW, 32'h0030, 32'h0);
        step(1'b0, LH, 32'h0032, 32'h0);
        step(1'b0, LHU, 32'h0032, 32'h0);
        step(1'b0, SW, 32'h3000, 32'hCAFEF00D);
        step(1'b0, LW, 32'h3000, 32'h0);
        step(1'b0, LW, 32'h0000, 32'h0);
        step(1'b1, SW, 32'h0040, 32'hDEADBEEF);
        step(1'b0, LW, 32'h0040, 32'h0);
        step(1'b0, LW, 32'h0010, 32'h0);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       ao = 32'h2FF0 + 32'($urandom_range(0, 63));
                1:       ao = {18'($urandom), 6'($urandom_range(0, 31)), 8'($urandom)} & 32'hFFFF_C07F;
                default: ao = 32'($urandom_range(0, 127));
            endcase
            step($urandom_range(0, 79) == 0, ops[$urandom_range(0, 9)], ao, $urandom);
        end
        step(1'b0, ADDU, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
